// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial output stage.
// Takes one WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock with framing strobes, then returns to idle.
// Optional build macro BYTE_SERIALIZER_PARITY_EN appends one even-parity bit
// to every frame.
//
// state  | meaning
// IDLE   | waiting for a word; In_Ready high
// SHIFT  | data bits on Ser_Out, WIDTH cycles
// PARITY | parity bit on Ser_Out (only with BYTE_SERIALIZER_PARITY_EN)
// DONE   | one-cycle Frame_Done pulse, then back to IDLE
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Ser_Out,
  output logic             Ser_Valid,
  output logic             Frame_Start,
  output logic             Frame_Done,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BYTE_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd2,
    PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg_next;
  logic             first_bit;
  logic             next_bit;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic             par_bit;
`endif

  // Ready only while idle and not held in reset.
  assign In_Ready = (state == IDLE) && !Rst;

  // Shift toward the output end with zero fill; pick the bits that go out next.
  always_comb begin
    shreg_next = '0;
    first_bit  = 1'b0;
    next_bit   = 1'b0;
    if (MSB_FIRST) begin
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
      first_bit  = In_Data[WIDTH-1];
      next_bit   = shreg[WIDTH-2];
    end else begin
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
      first_bit  = In_Data[0];
      next_bit   = shreg[1];
    end
  end

  // Frame sequencer; outputs are registered and loaded with next-cycle values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      Ser_Out     <= 1'b0;
      Ser_Valid   <= 1'b0;
      Frame_Start <= 1'b0;
      Frame_Done  <= 1'b0;
      Busy        <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      Frame_Start <= 1'b0;
      Frame_Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (In_Valid && In_Ready) begin
            state       <= SHIFT;
            shreg       <= In_Data;
            cnt         <= '0;
            Ser_Out     <= first_bit;
            Ser_Valid   <= 1'b1;
            Frame_Start <= 1'b1;
            Busy        <= 1'b1;
`ifdef BYTE_SERIALIZER_PARITY_EN
            par_bit     <= ^In_Data;
`endif
          end else begin
            Ser_Out   <= 1'b0;
            Ser_Valid <= 1'b0;
            Busy      <= 1'b0;
          end
        end
        SHIFT: begin
          shreg <= shreg_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
            state     <= PARITY;
            Ser_Out   <= par_bit;
            Ser_Valid <= 1'b1;
`else
            state      <= DONE;
            Ser_Out    <= 1'b0;
            Ser_Valid  <= 1'b0;
            Frame_Done <= 1'b1;
`endif
          end else begin
            Ser_Out <= next_bit;
          end
        end
`ifdef BYTE_SERIALIZER_PARITY_EN
        PARITY: begin
          state      <= DONE;
          Ser_Out    <= 1'b0;
          Ser_Valid  <= 1'b0;
          Frame_Done <= 1'b1;
        end
`endif
        DONE: begin
          state     <= IDLE;
          Ser_Out   <= 1'b0;
          Ser_Valid <= 1'b0;
          Busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          Ser_Out   <= 1'b0;
          Ser_Valid <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Testbench for byte_serializer: an MSB-first and an LSB-first instance share
// the same stimulus; each frame is compared against bit streams derived from
// the word by arithmetic. Honors BYTE_SERIALIZER_PARITY_EN like the design.
module tb_byte_serializer;

`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 10;
`endif

  logic       Clk;
  logic       Rst;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic rdy_m, so_m, sv_m, fs_m, fd_m, bz_m;
  logic rdy_l, so_l, sv_l, fs_l, fd_l, bz_l;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int accept_prev = 0;

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(rdy_m), .Ser_Out(so_m), .Ser_Valid(sv_m),
    .Frame_Start(fs_m), .Frame_Done(fd_m), .Busy(bz_m)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(rdy_l), .Ser_Out(so_l), .Ser_Valid(sv_l),
    .Frame_Start(fs_l), .Frame_Done(fd_l), .Busy(bz_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Bit i of the frame: the word shifted down so that the wanted bit is at 0.
  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    int pos;
    pos = msb ? (7 - i) : i;
    return ((w >> pos) & 8'h01) != 8'h00;
  endfunction

  function automatic logic exp_parity(input logic [7:0] w);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'((w >> k) & 8'h01);
    return (ones % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (rdy_m !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk("ready_wait", {31'd0, rdy_m}, 32'd1);
  endtask

  // One full frame: handshake, WIDTH data bits, optional parity, DONE, IDLE.
  task automatic frame(input logic [7:0] w, input bit keep_valid, input bit noise);
    wait_ready;
    In_Data  = w;
    In_Valid = 1'b1;
    tick;
    accept_prev = accept_cyc;
    accept_cyc  = cyc;
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        In_Valid = (i % 2) == 1;
        In_Data  = 8'h55;
      end else if (!keep_valid) begin
        In_Valid = 1'b0;
      end
      chk("sv_msb", {31'd0, sv_m}, 32'd1);
      chk("sv_lsb", {31'd0, sv_l}, 32'd1);
      chk("bit_msb", {31'd0, so_m}, {31'd0, exp_bit(w, i, 1'b1)});
      chk("bit_lsb", {31'd0, so_l}, {31'd0, exp_bit(w, i, 1'b0)});
      chk("frame_start", {31'd0, fs_m}, {31'd0, (i == 0)});
      chk("frame_start_l", {31'd0, fs_l}, {31'd0, (i == 0)});
      chk("fd_in_shift", {31'd0, fd_m}, 32'd0);
      chk("ready_in_shift", {31'd0, rdy_m}, 32'd0);
      chk("busy_in_shift", {31'd0, bz_m}, 32'd1);
      tick;
    end
    In_Valid = keep_valid;
    In_Data  = w;
`ifdef BYTE_SERIALIZER_PARITY_EN
    chk("par_valid", {31'd0, sv_m}, 32'd1);
    chk("par_msb", {31'd0, so_m}, {31'd0, exp_parity(w)});
    chk("par_lsb", {31'd0, so_l}, {31'd0, exp_parity(w)});
    chk("par_start", {31'd0, fs_m}, 32'd0);
    chk("par_fd", {31'd0, fd_m}, 32'd0);
    tick;
`endif
    chk("done_fd_msb", {31'd0, fd_m}, 32'd1);
    chk("done_fd_lsb", {31'd0, fd_l}, 32'd1);
    chk("done_sv", {31'd0, sv_m}, 32'd0);
    chk("done_so", {31'd0, so_m}, 32'd0);
    chk("done_ready", {31'd0, rdy_m}, 32'd0);
    chk("done_busy", {31'd0, bz_m}, 32'd1);
    tick;
    chk("idle_fd", {31'd0, fd_m}, 32'd0);
    chk("idle_sv", {31'd0, sv_m}, 32'd0);
    chk("idle_busy", {31'd0, bz_m}, 32'd0);
    chk("idle_ready", {31'd0, rdy_m}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic [7:0] w;

    // Reset held with a valid word offered: nothing may be captured.
    Rst      = 1'b1;
    In_Valid = 1'b1;
    In_Data  = 8'hA5;
    for (int r = 0; r < 3; r++) begin
      tick;
      chk("rst_ready", {31'd0, rdy_m}, 32'd0);
      chk("rst_sv", {31'd0, sv_m}, 32'd0);
      chk("rst_busy", {31'd0, bz_m}, 32'd0);
      chk("rst_fd", {31'd0, fd_m}, 32'd0);
    end
    Rst      = 1'b0;
    In_Valid = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, rdy_m}, 32'd1);
    tick;
    chk("post_rst_sv", {31'd0, sv_m}, 32'd0);
    chk("post_rst_busy", {31'd0, bz_m}, 32'd0);

    // Directed patterns.
    frame(8'hA5, 1'b0, 1'b0);
    frame(8'h07, 1'b0, 1'b0);

    // Back-to-back with In_Valid held high.
    frame(8'h3C, 1'b1, 1'b0);
    In_Data = 8'hC3;
    frame(8'hC3, 1'b0, 1'b0);
    chk("b2b_gap", accept_cyc - accept_prev, PERIOD);

    // Mid-frame reset after the 4th bit of 0xFF.
    wait_ready;
    In_Data  = 8'hFF;
    In_Valid = 1'b1;
    tick;
    In_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_bit", {31'd0, so_m}, 32'd1);
      tick;
    end
    Rst = 1'b1;
    tick;
    chk("abort_sv", {31'd0, sv_m}, 32'd0);
    chk("abort_fd", {31'd0, fd_m}, 32'd0);
    chk("abort_busy", {31'd0, bz_m}, 32'd0);
    chk("abort_ready", {31'd0, rdy_m}, 32'd0);
    Rst = 1'b0;
    #1;
    chk("abort_release_ready", {31'd0, rdy_m}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_fd", {31'd0, fd_m}, 32'd0);
      chk("abort_idle_sv", {31'd0, sv_m}, 32'd0);
    end
    frame(8'h81, 1'b0, 1'b0);

    // In_Valid pulses of 0x55 while shifting must be ignored.
    frame(8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("noise_not_captured", {31'd0, sv_m}, 32'd0);
    end

    // Random words with random idle gaps.
    for (int n = 0; n < 6; n++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick;
        chk("gap_sv", {31'd0, sv_m}, 32'd0);
      end
      w = 8'($urandom);
      frame(w, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
